// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  // Clear-engine states: idle, sweeping one register per cycle, one-cycle done.
  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  // Default geometry matching the datapath's original 16x16 register file.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: sweeps every register to zero, one per cycle, and gates
// normal writes while the sweep (or its done cycle) is in progress.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop,
  output logic              wr_ok,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Address of the final register; the sweep exits on this compare, not on wrap.
  localparam logic [ADDR_W-1:0] LAST = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // Sequencer state, sweep counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every flop here is updated with <= so all of them sample the
    // pre-edge values of each other; blocking = would make order matter.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= we && (state != IDLE);
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state    <= DONE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // A write lands only from IDLE and never into a hard-wired zero register.
  assign wr_ok    = we && (state == IDLE) && !((ZERO_R0 != 0) && (wr_addr == '0));
  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with N_RD read ports, optional registered reads,
// write-to-read bypass, optional zero register and a sequenced clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_RD    = 2,
  parameter int RD_REG  = 0,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W),
    .ZERO_R0(ZERO_R0)
  ) u_clr_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .we      (we),
    .wr_addr (wr_addr),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .wr_drop (wr_drop),
    .wr_ok   (wr_ok),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // Storage array: cleared by reset, swept by the clear engine, written from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array needs a reset value, so it is built from flops rather
    // than a RAM macro; a RAM could not clear all entries asynchronously.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr_we) mem[clr_addr] <= '0;
      if (wr_ok)  mem[wr_addr]  <= wr_data;
    end
  end

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] cur;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

    // Current read value: array content, overridden by a same-cycle write and
    // finally by the hard-wired zero register.
    always_comb begin
      // NOTE: cur gets a default before any conditional override so no path
      // leaves it unassigned, which would otherwise infer a latch.
      cur = mem[addr];
      if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) cur = wr_data;
      if ((ZERO_R0 != 0) && (addr == '0))              cur = '0;
    end

    if (RD_REG != 0) begin : g_reg
      logic [DATA_W-1:0] nxt;
      logic [DATA_W-1:0] rd_q;

      // With bypass, the captured value is the post-edge content, which also
      // reflects a register being swept to zero on this edge.
      always_comb begin
        nxt = cur;
        if ((BYPASS != 0) && clr_we && (clr_addr == addr)) nxt = '0;
      end

      // Registered read port with one cycle of latency.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else     rd_q <= nxt;
      end

      assign rd_data[g*DATA_W +: DATA_W] = rd_q;
    end else begin : g_comb
      assign rd_data[g*DATA_W +: DATA_W] = cur;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four instances in different configurations share one
// stimulus stream; an array-based model is compared on every falling edge and
// directed literal expectations pin the model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;
  logic        clr_req;

  logic [31:0] rdat [4];
  logic [3:0]  busy;
  logic [3:0]  done;
  logic [3:0]  drop;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  // u0: default comb/bypass, u1: no bypass, u2: registered reads, u3: zero r0.
  regfile_mp #(.RD_REG(0), .BYPASS(1), .ZERO_R0(0)) u0 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdat[0]), .clr_req(clr_req),
    .clr_busy(busy[0]), .clr_done(done[0]), .wr_drop(drop[0]));
  regfile_mp #(.RD_REG(0), .BYPASS(0), .ZERO_R0(0)) u1 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdat[1]), .clr_req(clr_req),
    .clr_busy(busy[1]), .clr_done(done[1]), .wr_drop(drop[1]));
  regfile_mp #(.RD_REG(1), .BYPASS(1), .ZERO_R0(0)) u2 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdat[2]), .clr_req(clr_req),
    .clr_busy(busy[2]), .clr_done(done[2]), .wr_drop(drop[2]));
  regfile_mp #(.RD_REG(0), .BYPASS(1), .ZERO_R0(1)) u3 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdat[3]), .clr_req(clr_req),
    .clr_busy(busy[3]), .clr_done(done[3]), .wr_drop(drop[3]));

  function automatic bit cfg_rdreg(int c); return c == 2; endfunction
  function automatic bit cfg_byp(int c);   return c != 1; endfunction
  function automatic bit cfg_zr(int c);    return c == 3; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 sweeping, 2 done cycle; idx = next register to zero.
  logic [15:0] mem  [4][16];
  logic [15:0] pre  [16];
  logic [15:0] rreg [4][2];
  int          phase [4];
  int          idx   [4];
  bit          mdrop [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 16; i++) mem[c][i] = '0;
        rreg[c][0] = '0;
        rreg[c][1] = '0;
        phase[c]   = 0;
        idx[c]     = 0;
        mdrop[c]   = 1'b0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 16; i++) pre[i] = mem[c][i];
        mdrop[c] = (phase[c] != 0) && we;
        if (phase[c] == 0) begin
          if (we && !(cfg_zr(c) && wr_addr == 4'd0)) mem[c][wr_addr] = wr_data;
          if (clr_req) begin
            phase[c] = 1;
            idx[c]   = 0;
          end
        end else if (phase[c] == 1) begin
          mem[c][idx[c]] = '0;
          if (idx[c] == 15) phase[c] = 2;
          else              idx[c]++;
        end else begin
          phase[c] = 0;
        end
        for (int p = 0; p < 2; p++) begin
          logic [3:0]  a;
          logic [15:0] v;
          a = rd_addr[p*4 +: 4];
          v = cfg_byp(c) ? mem[c][a] : pre[a];
          if (cfg_zr(c) && a == 4'd0) v = '0;
          rreg[c][p] = v;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("u%0d busy", c), busy[c], phase[c] == 1);
        check($sformatf("u%0d done", c), done[c], phase[c] == 2);
        check($sformatf("u%0d drop", c), drop[c], mdrop[c]);
        for (int p = 0; p < 2; p++) begin
          logic [3:0]  a;
          logic [15:0] e;
          a = rd_addr[p*4 +: 4];
          if (cfg_rdreg(c)) begin
            e = rreg[c][p];
          end else begin
            e = mem[c][a];
            if (cfg_byp(c) && we && phase[c] == 0 && wr_addr == a &&
                !(cfg_zr(c) && wr_addr == 4'd0)) e = wr_data;
            if (cfg_zr(c) && a == 4'd0) e = '0;
          end
          check($sformatf("u%0d rd%0d", c, p), rdat[c][p*16 +: 16], e);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    int  busy_cnt;
    int  done_cnt;
    int  k;
    bit  hit;

    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = 8'h10; clr_req = 1'b0;
    step();
    chk_en = 1'b1;

    // 1. reset state and basic write/read
    #2;
    for (int c = 0; c < 4; c++) check($sformatf("u%0d reset rd", c), rdat[c], 32'h0);
    rst = 1'b0;
    step();
    wr(4'd0, 16'h0001);
    wr(4'd1, 16'h0007);
    #2;
    check("basic r0/r1", rdat[0], 32'h0007_0001);
    check("zr r0/r1",    rdat[3], 32'h0007_0000);

    // 2. bypass vs no bypass
    wr(4'd3, 16'h1111);
    we = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_addr = 8'h13;
    #2;
    check("bypass A",    {16'h0, rdat[0][15:0]}, 32'h0000_BEEF);
    check("no bypass A", {16'h0, rdat[1][15:0]}, 32'h0000_1111);
    step();
    we = 1'b0;
    #2;
    check("no bypass post", {16'h0, rdat[1][15:0]}, 32'h0000_BEEF);

    // 3. registered read: write r5 while reading r5
    rd_addr = 8'h15;
    wr(4'd5, 16'h00A5);
    #2;
    check("rdreg A", {16'h0, rdat[2][15:0]}, 32'h0000_00A5);

    // 4/5. fill, sweep, write during sweep, re-request during sweep
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h0100 + 16'(i));
    rd_addr = 8'hF0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #2;
      hit = busy[0];
      if (hit) begin
        k = busy_cnt;
        check($sformatf("sweep%0d A", k), {16'h0, rdat[0][15:0]},
              (k == 0) ? 32'h0000_0100 : 32'h0);
        check($sformatf("sweep%0d r15", k), {16'h0, rdat[0][31:16]}, 32'h0000_010F);
        if (k == 4) check("drop after sweep wr", drop[0], 1'b1);
        busy_cnt++;
      end
      if (done[0]) done_cnt++;
      we      = hit && (k == 3);
      wr_addr = 4'd15;
      wr_data = 16'h7777;
      clr_req = hit && (k == 6);
      rd_addr = {4'd15, hit ? 4'(k) : 4'd0};
      step();
    end
    we = 1'b0; clr_req = 1'b0;
    check("busy cycles", busy_cnt, 16);
    check("done pulses", done_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      rd_addr = {4'(15 - i), 4'(i)};
      #1;
      check($sformatf("cleared r%0d", i), rdat[0], 32'h0);
    end
    step();

    // 6. zero register write, then reset mid-sweep
    rd_addr = 8'h90;
    we = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    #2;
    check("zr write bypass", {16'h0, rdat[3][15:0]}, 32'h0);
    check("r0 write bypass", {16'h0, rdat[0][15:0]}, 32'h0000_FFFF);
    step();
    we = 1'b0;
    #2;
    check("zr r0 read", {16'h0, rdat[3][15:0]}, 32'h0);
    check("zr no drop", drop[3], 1'b0);
    wr(4'd9, 16'h1234);
    #2;
    check("r9 written", rdat[0], 32'h1234_FFFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
      #2;
      if (busy[0]) begin
        if (busy_cnt == 8) begin
          hit = 1'b1;
          rst = 1'b1;
          #1;
          check("rst busy", busy, 4'b0000);
          check("rst done", done, 4'b0000);
          for (int c = 0; c < 4; c++) check($sformatf("u%0d rst rd", c), rdat[c], 32'h0);
        end
        busy_cnt++;
      end
      if (!hit) step();
    end
    check("sweep cycle 8 reached", hit, 1'b1);
    step();
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      #2;
      if (done[0]) done_cnt++;
      if (busy[0]) busy_cnt++;
      step();
    end
    check("no done after rst", done_cnt, 0);
    check("no busy after rst", busy_cnt, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file.
- Successor to the fixed 16x16, two-read-port register file used in the datapath.
- Adds:
  - configurable data width, depth and read-port count
  - optional registered reads
  - write-to-read bypass
  - hard-wired zero register option
  - asynchronous reset
  - a sequenced clear engine (one register per cycle) with busy/done handshake
- Sits between the control unit and the ALU; the control unit issues clears and writes, and the ALU consumes the read ports.

Parameters:
- DATA_W, 16, width of each register in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- N_RD, 2, number of independent read ports (1..4)
- RD_REG, 0, 0 = combinational read data; 1 = read data registered at posedge clk (1-cycle latency)
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns wr_data
- ZERO_R0, 0, 1 = register 0 always reads 0; writes to it are discarded

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  N_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
- clr_req  in  1  request to clear all registers (sampled in IDLE only)
- clr_busy  out  1  high while the clear sweep is in progress
- clr_done  out  1  one-cycle pulse after the last register is cleared
- wr_drop  out  1  one-cycle pulse, registered, flags a write discarded because a clear was in progress

Behaviour:
- Reset (rst=1, asynchronous):
  - all DEPTH registers = 0
  - FSM = IDLE, sweep counter = 0
  - clr_busy = 0, clr_done = 0, wr_drop = 0
  - registered rd_data (RD_REG=1) = 0
- Write:
  - in IDLE, when we=1, wr_data is stored at wr_addr on posedge.
  - ZERO_R0=1 and wr_addr=0: the write is silently discarded, and wr_drop is not asserted.
- Read, RD_REG=0:
  - rd_data[i] = reg[rd_addr[i]] combinationally.
  - If BYPASS=1, we=1, state is IDLE and wr_addr==rd_addr[i] (and the write is not discarded by ZERO_R0), rd_data[i] = wr_data instead.
- Read, RD_REG=1:
  - rd_data[i] is registered on posedge.
  - The captured value follows the same bypass rule (write-first), so it equals the post-edge content of the register.
- ZERO_R0=1: rd_addr[i]=0 always yields 0, overriding bypass.
- Multiple ports addressing the same register all return identical data.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR when clr_req=1. Counter = 0, and clr_busy goes high from the next cycle.
  - CLEAR: on each posedge, reg[counter] <= 0 and counter increments.
    - After clearing register DEPTH-1, go to DONE. The sweep takes exactly DEPTH cycles.
    - Counter wrap to 0 is not used to exit; the explicit terminal compare is.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then go to IDLE.
  - clr_busy = (state==CLEAR).
  - clr_req in CLEAR or DONE is ignored; there is no queueing.
- Writes during CLEAR or DONE:
  - the write is discarded
  - wr_drop pulses high on the following cycle
  - bypass is disabled
- Reads during CLEAR return current contents: already-swept registers read 0, unswept registers read old data.
- rst asserted mid-sweep: immediate return to IDLE with all registers 0; clr_done does not pulse.

Decomposition:
- Shared package regfile_pkg:
  - typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t
  - localparam defaults for DATA_W/ADDR_W, used by the datapath top level
- One natural sub-module: regfile_clr_fsm.
  - Contains the state, sweep counter, clr_busy, clr_done and the write-gating signal.
  - Outputs clr_we/clr_addr to the array.
- Read ports are generated with a generate loop over N_RD inside regfile_mp.

Test Plan (DATA_W=16, ADDR_W=4, N_RD=2 unless noted):
1. Reset/basic write-read:
   - stimulus: rst pulse; write 0x0001 to r0, then 0x0007 to r1; read A=0, B=1
   - required: A=0x0001, B=0x0007; before any write, all reads = 0x0000
2. Bypass, BYPASS=1, RD_REG=0:
   - stimulus: r3=0x1111; in the same cycle, write 0xBEEF to r3 with rd_addr A=3
   - required: A=0xBEEF during that cycle
   - with BYPASS=0, A=0x1111 until the edge
3. Registered read, RD_REG=1:
   - stimulus: write 0x00A5 to r5 while reading r5
   - required: rd_data=0x00A5 one cycle after the edge; after rst, rd_data=0
4. Clear sweep:
   - stimulus: fill r0..r15 with 0x0100+i; pulse clr_req
   - required: clr_busy high for exactly 16 cycles; at sweep cycle k, reads of r0..r(k-1)=0 and r15 remains 0x010F until the last cycle; then clr_done pulses once; all registers read 0
5. Write during sweep:
   - stimulus: write 0x7777 to r15 at sweep cycle 3
   - required: wr_drop pulses one cycle later; r15=0x0000 after clr_done
   - stimulus: clr_req re-pulsed during the sweep
   - required: ignored (still one clr_done)
6. ZERO_R0=1 and reset mid-sweep:
   - stimulus: write 0xFFFF to r0
   - required: reads return 0, no wr_drop
   - stimulus: assert rst at sweep cycle 8
   - required: clr_busy=0 immediately, all registers 0, no clr_done
